// File: rtl/step_pulse_gen_if.sv
// Button/switch inputs and step outputs exchanged between the debounce/auto-run
// block and its user (LFSR stage, display, testbench).
interface step_pulse_gen_if;
  logic       btn;
  logic       auto_en;
  logic       step;
  logic       btn_level;
  logic [7:0] step_cnt;

  modport master (
    output btn,
    output auto_en,
    input  step,
    input  btn_level,
    input  step_cnt
  );

  modport slave (
    input  btn,
    input  auto_en,
    output step,
    output btn_level,
    output step_cnt
  );
endinterface

// File: rtl/step_pulse_gen.sv
// Debounced push-button and periodic auto-run producing a one-cycle step pulse
// for the LFSR stage, plus a wrapping count of issued steps.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE_LO | button accepted as released, waiting for a rising sample
// WAIT_HI | counting consecutive high samples before accepting a press
// IDLE_HI | button accepted as pressed, waiting for a falling sample
// WAIT_LO | counting consecutive low samples before accepting a release
module step_pulse_gen #(
  parameter int DEB_CYCLES  = 16,
  parameter int AUTO_PERIOD = 1000,
  parameter int CNT_W       = 32
) (
  input logic             clk,
  input logic             rst,
  step_pulse_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } deb_state_t;

  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(AUTO_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       btn_sync_q, btn_sync_d;
  logic [1:0]       auto_sync_q, auto_sync_d;
  logic             btn_s, auto_s;

  deb_state_t       state_q, state_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic             btn_level_q, btn_level_d;
  logic             step_q, step_d;
  logic [7:0]       step_cnt_q, step_cnt_d;

  logic             btn_req;
  logic             auto_req;

  // Two-flop synchronizers; bit 1 is the settled sample.
  always_comb begin
    btn_sync_d  = {btn_sync_q[0], bus.btn};
    auto_sync_d = {auto_sync_q[0], bus.auto_en};
  end

  assign btn_s  = btn_sync_q[1];
  assign auto_s = auto_sync_q[1];

  always_comb begin
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    btn_level_d = btn_level_q;
    btn_req     = 1'b0;
    case (state_q)
      IDLE_LO: begin
        if (btn_s) begin
          state_d = WAIT_HI;
          dcnt_d  = CNT_ONE;
        end
      end
      WAIT_HI: begin
        if (!btn_s) begin
          state_d = IDLE_LO;
          dcnt_d  = '0;
        end else if (dcnt_q >= DEB_MAX) begin
          state_d     = IDLE_HI;
          dcnt_d      = '0;
          btn_level_d = 1'b1;
          btn_req     = 1'b1;
        end else begin
          dcnt_d = dcnt_q + CNT_ONE;
        end
      end
      IDLE_HI: begin
        if (!btn_s) begin
          state_d = WAIT_LO;
          dcnt_d  = CNT_ONE;
        end
      end
      WAIT_LO: begin
        // Release acceptance only updates the level; it never requests a step.
        if (btn_s) begin
          state_d = IDLE_HI;
          dcnt_d  = '0;
        end else if (dcnt_q >= DEB_MAX) begin
          state_d     = IDLE_LO;
          dcnt_d      = '0;
          btn_level_d = 1'b0;
        end else begin
          dcnt_d = dcnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d     = IDLE_LO;
        dcnt_d      = '0;
        btn_level_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    pcnt_d   = pcnt_q;
    auto_req = 1'b0;
    if (!auto_s) begin
      pcnt_d = '0;
    end else if (pcnt_q == PER_LAST) begin
      pcnt_d   = '0;
      auto_req = 1'b1;
    end else begin
      pcnt_d = pcnt_q + CNT_ONE;
    end
  end

  // Coincident button and auto requests merge into a single pulse.
  always_comb begin
    step_d     = btn_req | auto_req;
    step_cnt_d = step_d ? step_cnt_q + 8'd1 : step_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_sync_q  <= '0;
      auto_sync_q <= '0;
      state_q     <= IDLE_LO;
      dcnt_q      <= '0;
      pcnt_q      <= '0;
      btn_level_q <= 1'b0;
      step_q      <= 1'b0;
      step_cnt_q  <= '0;
    end else begin
      btn_sync_q  <= btn_sync_d;
      auto_sync_q <= auto_sync_d;
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      pcnt_q      <= pcnt_d;
      btn_level_q <= btn_level_d;
      step_q      <= step_d;
      step_cnt_q  <= step_cnt_d;
    end
  end

  assign bus.step      = step_q;
  assign bus.btn_level = btn_level_q;
  assign bus.step_cnt  = step_cnt_q;

endmodule
